mem_copy_engine: RTL and testbench

- Bus-master copy engine that drives the two-port memory interface as initiator: read port (rready/raddr, rresp/rdata) and write port (wready/waddr/wdata/wstrb).
- Copies a block of 32-bit words from a source to a destination region, one word per cycle, with reads and writes overlapped.
- Sits between a control register block or the core and the data-memory port; used for block moves, test-image setup and memory clearing.

---
 rtl/mem_copy_engine.sv | 194 +++++++++++++++++++
 tb/tb_mem_copy_engine.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: bus-master block copy engine.
// Copies len 32-bit words from src to dst, one word per cycle, with reads and
// writes overlapped in a strictly ascending schedule. Write data is taken from
// the read response one cycle after it arrives, so word i is written two
// cycles after it was read.
// Optional build macro MEMCOPY_FILL_EN adds a fill mode (writes fill_val to
// the destination, no reads). Without it, fill and fill_val are ignored.
module mem_copy_engine #(
   parameter int LENW = 16
) (
   input  logic            clk,
   input  logic            resetb,
   input  logic            start,
   input  logic [31:0]     src,
   input  logic [31:0]     dst,
   input  logic [LENW-1:0] len,
   input  logic            abort,
   input  logic            fill,
   input  logic [31:0]     fill_val,
   output logic            busy,
   output logic            done,
   output logic            aborted,
   output logic            rready,
   output logic [30:0]     raddr,
   input  logic            rresp,
   input  logic [31:0]     rdata,
   output logic            wready,
   output logic [29:0]     waddr,
   output logic [31:0]     wdata,
   output logic [3:0]      wstrb
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   localparam logic [LENW-1:0] CNT_ONE = LENW'(1);

   state_t          state_q, state_d;
   logic [29:0]     src_q, src_d;        // source word address
   logic [29:0]     dst_q, dst_d;        // destination word address
   logic [LENW-1:0] len_q, len_d;
   logic [LENW-1:0] rd_cnt_q, rd_cnt_d;
   logic [LENW-1:0] wr_cnt_q, wr_cnt_d;
   logic            aborted_q, aborted_d;
   logic            wready_q, wready_d;
   logic [29:0]     waddr_q, waddr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            fill_q, fill_d;
   logic [31:0]     fill_val_q, fill_val_d;

   logic            rd_issue;            // read presented this cycle
   logic            fill_wr;             // fill write presented this cycle
   logic            in_xfer;
   logic [29:0]     rd_word;
   logic [29:0]     wr_word;
   logic [LENW-1:0] len_m1;

`ifdef MEMCOPY_FILL_EN
   logic unused_lsb;
   assign unused_lsb = ^{src[1:0], dst[1:0]};
`else
   logic unused_fill;
   assign unused_fill = ^{fill, fill_val, src[1:0], dst[1:0]};
`endif

   // Word arithmetic on 30 bits is byte arithmetic modulo 2^32 with [1:0]=0.
   assign rd_word = src_q + 30'(rd_cnt_q);
   assign wr_word = dst_q + 30'(wr_cnt_q);
   assign len_m1  = len_q - CNT_ONE;
   assign in_xfer = (state_q == S_RUN) || (state_q == S_DRAIN);

   // Next-state, read issue, fill writes and capture of read responses.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      rd_cnt_d   = rd_cnt_q;
      wr_cnt_d   = wr_cnt_q;
      aborted_d  = aborted_q;
      wready_d   = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      fill_d     = fill_q;
      fill_val_d = fill_val_q;
      rd_issue   = 1'b0;
      fill_wr    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d     = src[31:2];
               dst_d     = dst[31:2];
               len_d     = len;
               rd_cnt_d  = '0;
               wr_cnt_d  = '0;
               aborted_d = 1'b0;
`ifdef MEMCOPY_FILL_EN
               fill_d     = fill;
               fill_val_d = fill_val;
`else
               fill_d     = 1'b0;
               fill_val_d = '0;
`endif
               state_d = (len == '0) ? S_FIN : S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_FIN;
            end else if (fill_q) begin
               fill_wr  = 1'b1;
               wr_cnt_d = wr_cnt_q + CNT_ONE;
               if (wr_cnt_q == len_m1) state_d = S_FIN;
            end else begin
               rd_issue = 1'b1;
               rd_cnt_d = rd_cnt_q + CNT_ONE;
               if (rd_cnt_q == len_m1) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_FIN;
            end else if (wready_q && (wr_cnt_q == len_q)) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A response in the abort cycle or outside a copy never becomes a write.
      if (in_xfer && !fill_q && !abort && rresp) begin
         wready_d = 1'b1;
         waddr_d  = wr_word;
         wdata_d  = rdata;
         wr_cnt_d = wr_cnt_q + CNT_ONE;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (resetb) begin
         state_q    <= S_IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         aborted_q  <= 1'b0;
         wready_q   <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         fill_q     <= 1'b0;
         fill_val_q <= '0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         len_q      <= len_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         aborted_q  <= aborted_d;
         wready_q   <= wready_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         fill_q     <= fill_d;
         fill_val_q <= fill_val_d;
      end
   end

   assign busy    = in_xfer;
   assign done    = (state_q == S_FIN);
   assign aborted = aborted_q;
   assign rready  = rd_issue;
   assign raddr   = rd_issue ? {rd_word, 1'b0} : '0;
   assign wready  = wready_q | fill_wr;
   assign waddr   = fill_wr ? wr_word : waddr_q;
   assign wdata   = fill_wr ? fill_val_q : wdata_q;
   assign wstrb   = 4'hf;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed testbench for mem_copy_engine: a one-cycle-latency memory with
// write-to-read forwarding, per-cycle address checks and post-run memory checks.
module tb_mem_copy_engine;

   localparam int LENW = 16;

   logic            clk = 1'b0;
   logic            resetb, start, abort, fill;
   logic [31:0]     src, dst, fill_val;
   logic [LENW-1:0] len;
   logic            busy, done, aborted, rready, wready, rresp;
   logic [30:0]     raddr;
   logic [29:0]     waddr;
   logic [31:0]     wdata, rdata;
   logic [3:0]      wstrb;

   logic [31:0]     mem [0:1023];

   int n_cmp = 0;
   int n_err = 0;
   int rd_first, rd_last, rd_num, wr_first, wr_last, wr_num;
   int done_cyc, done_num, busy_num;
   logic ab_seen;

   mem_copy_engine #(.LENW(LENW)) dut (
      .clk(clk), .resetb(resetb), .start(start), .src(src), .dst(dst),
      .len(len), .abort(abort), .fill(fill), .fill_val(fill_val),
      .busy(busy), .done(done), .aborted(aborted), .rready(rready),
      .raddr(raddr), .rresp(rresp), .rdata(rdata), .wready(wready),
      .waddr(waddr), .wdata(wdata), .wstrb(wstrb)
   );

   always #5 clk = ~clk;

   // Memory: response one cycle after the request; same-cycle write forwards.
   always @(posedge clk) begin
      rresp <= rready;
      if (rready)
         rdata <= (wready && (waddr[9:0] == raddr[10:1])) ? wdata : mem[raddr[10:1]];
      if (wready)
         mem[waddr[9:0]] <= wdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Starts a transfer in cycle 0 and observes cycles 1..n+8.
   task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                           input int abort_at, input int reset_at, input logic f);
      logic [31:0] ra;
      logic [31:0] wa;
      rd_first = -1; rd_last = -1; rd_num = 0;
      wr_first = -1; wr_last = -1; wr_num = 0;
      done_cyc = -1; done_num = 0; busy_num = 0; ab_seen = 1'b0;
      @(posedge clk); #2;
      src = s; dst = d; len = LENW'(n); fill = f; start = 1'b1;
      for (int c = 1; c <= n + 8; c++) begin
         @(posedge clk); #2;
         start  = 1'b0;
         abort  = (c == abort_at);
         resetb = (c == reset_at);
         #1;
         if (rready) begin
            ra = (s & ~32'h3) + 32'(4 * rd_num);
            check("raddr", {1'b0, raddr}, {1'b0, ra[31:1]});
            if (rd_num == 0) rd_first = c;
            rd_last = c;
            rd_num++;
         end
         if (wready) begin
            wa = (d & ~32'h3) + 32'(4 * wr_num);
            check("waddr", {2'b00, waddr}, {2'b00, wa[31:2]});
            check("wstrb", 32'(wstrb), 32'hf);
            if (wr_num == 0) wr_first = c;
            wr_last = c;
            wr_num++;
         end
         if (done) begin
            done_cyc = c;
            done_num++;
            ab_seen  = aborted;
         end
         if (busy) busy_num++;
         if (c == reset_at + 1) begin
            check("rst_busy",   32'(busy),   32'd0);
            check("rst_rready", 32'(rready), 32'd0);
            check("rst_wready", 32'(wready), 32'd0);
         end
      end
      abort  = 1'b0;
      resetb = 1'b0;
   endtask

   initial begin
      resetb = 1'b1; start = 1'b0; abort = 1'b0; fill = 1'b0;
      src = '0; dst = '0; len = '0; fill_val = 32'hDEADBEEF;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h5A5A0000 | 32'(i);
      for (int i = 0; i < 8; i++) mem[32'h40 + i] = 32'h11 * 32'(i + 1);
      mem[32'hC0] = 32'hAAAA0000; mem[32'hC1] = 32'hBBBB0000;
      mem[32'hC2] = 32'hCCCC0000; mem[32'hC3] = 32'hDDDD0000;

      // Reset state
      repeat (3) @(posedge clk);
      #3;
      check("rst_busy0",   32'(busy),    32'd0);
      check("rst_done0",   32'(done),    32'd0);
      check("rst_abort0",  32'(aborted), 32'd0);
      check("rst_rready0", 32'(rready),  32'd0);
      check("rst_wready0", 32'(wready),  32'd0);
      check("rst_raddr0",  32'(raddr),   32'd0);
      check("rst_waddr0",  32'(waddr),   32'd0);
      check("rst_wdata0",  wdata,        32'd0);
      check("rst_wstrb0",  32'(wstrb),   32'hf);
      @(posedge clk); #2;
      resetb = 1'b0;

      // Plain copy of 4 words: 0x100 -> 0x200
      run_xfer(32'h100, 32'h200, 4, -1, -1, 1'b0);
      check("cp_rd_first", 32'(rd_first), 32'd1);
      check("cp_rd_last",  32'(rd_last),  32'd4);
      check("cp_wr_first", 32'(wr_first), 32'd3);
      check("cp_wr_last",  32'(wr_last),  32'd6);
      check("cp_wr_num",   32'(wr_num),   32'd4);
      check("cp_done",     32'(done_cyc), 32'd7);
      check("cp_done_num", 32'(done_num), 32'd1);
      check("cp_busy_num", 32'(busy_num), 32'd6);
      check("cp_aborted",  32'(ab_seen),  32'd0);
      check("cp_m80", mem[32'h80], 32'h11);
      check("cp_m81", mem[32'h81], 32'h22);
      check("cp_m82", mem[32'h82], 32'h33);
      check("cp_m83", mem[32'h83], 32'h44);
      check("cp_m84", mem[32'h84], 32'h5A5A0084);

      // Zero-length transfer
      run_xfer(32'h100, 32'h240, 0, -1, -1, 1'b0);
      check("z_rd_num",   32'(rd_num),   32'd0);
      check("z_wr_num",   32'(wr_num),   32'd0);
      check("z_done",     32'(done_cyc), 32'd1);
      check("z_busy_num", 32'(busy_num), 32'd0);
      check("z_aborted",  32'(ab_seen),  32'd0);

      // Abort at cycle 4 of an 8-word copy: 0x100 -> 0x280
      run_xfer(32'h100, 32'h280, 8, 4, -1, 1'b0);
      check("ab_rd_num",   32'(rd_num),   32'd3);
      check("ab_rd_last",  32'(rd_last),  32'd3);
      check("ab_wr_num",   32'(wr_num),   32'd2);
      check("ab_wr_last",  32'(wr_last),  32'd4);
      check("ab_done",     32'(done_cyc), 32'd5);
      check("ab_done_num", 32'(done_num), 32'd1);
      check("ab_aborted",  32'(ab_seen),  32'd1);
      check("ab_mA0", mem[32'hA0], 32'h11);
      check("ab_mA1", mem[32'hA1], 32'h22);
      check("ab_mA2", mem[32'hA2], 32'h5A5A00A2);

      // Overlapping regions, dst = src + 4: ascending schedule
      run_xfer(32'h300, 32'h304, 3, -1, -1, 1'b0);
      check("ov_done", 32'(done_cyc), 32'd6);
      check("ov_mC0", mem[32'hC0], 32'hAAAA0000);
      check("ov_mC1", mem[32'hC1], 32'hAAAA0000);
      check("ov_mC2", mem[32'hC2], 32'hBBBB0000);
      check("ov_mC3", mem[32'hC3], 32'hCCCC0000);

      // Reset at cycle 3 of a 6-word copy, then a normal copy
      run_xfer(32'h100, 32'h380, 6, -1, 3, 1'b0);
      check("rs_done_num", 32'(done_num), 32'd0);
      check("rs_rd_num",   32'(rd_num),   32'd3);
      check("rs_wr_num",   32'(wr_num),   32'd1);
      check("rs_mE0", mem[32'hE0], 32'h11);
      check("rs_mE1", mem[32'hE1], 32'h5A5A00E1);
      run_xfer(32'h10B, 32'h3A2, 2, -1, -1, 1'b0);
      check("rs2_rd_num",  32'(rd_num),   32'd2);
      check("rs2_done",    32'(done_cyc), 32'd5);
      check("rs2_aborted", 32'(ab_seen),  32'd0);
      check("rs2_mE8", mem[32'hE8], 32'h33);
      check("rs2_mE9", mem[32'hE9], 32'h44);

`ifdef MEMCOPY_FILL_EN
      // Fill 5 words at 0x3C0
      run_xfer(32'h0, 32'h3C0, 5, -1, -1, 1'b1);
      check("fl_rd_num",   32'(rd_num),   32'd0);
      check("fl_wr_first", 32'(wr_first), 32'd1);
      check("fl_wr_last",  32'(wr_last),  32'd5);
      check("fl_done",     32'(done_cyc), 32'd6);
      check("fl_busy_num", 32'(busy_num), 32'd5);
      for (int i = 0; i < 5; i++) check("fl_mem", mem[32'hF0 + i], 32'hDEADBEEF);
      check("fl_mF5", mem[32'hF5], 32'h5A5A00F5);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
